// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Scans two 4-digit multiplexed 7-segment displays (D0, D1) in lockstep
//   from a 32-bit hex value. Each digit slot starts with a blanking interval
//   to suppress ghosting. Inputs are snapshotted once per frame so a frame
//   never shows a mix of old and new data.
//
//   Optional feature macro: SEG7_BRIGHTNESS_EN
//     When defined, adds a 4-bit brightness input that shortens the lit part
//     of each SHOW phase (brightness = 15 is full-on).
//
// Ports:
//   mclk        system clock
//   rst         synchronous active-high reset
//   value       [15:0] -> D0, [31:16] -> D1; nibble k -> digit k (0 = rightmost)
//   dp          decimal points, [3:0] D0, [7:4] D1, 1 = lit
//   digit_en    per-digit enable, same mapping as dp, 0 = digit blank
//   brightness  (SEG7_BRIGHTNESS_EN only) lit fraction = (brightness+1)/16
//   D0_seg      {dp,g,f,e,d,c,b,a}, active-low
//   D1_seg      same encoding as D0_seg
//   D0_a        anodes, active-low, bit k = digit k
//   D1_a        same as D0_a
//   frame_tick  one-cycle pulse with the last SHOW cycle of digit 3
module seg7_scan_driver #(
    parameter int unsigned DWELL_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic [7:0]  dp,
    input  logic [7:0]  digit_en,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]  brightness,
`endif
    output logic [7:0]  D0_seg,
    output logic [7:0]  D1_seg,
    output logic [3:0]  D0_a,
    output logic [3:0]  D1_a,
    output logic        frame_tick
);

    localparam int unsigned CW = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] LAST_CNT   = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {PH_BLANK, PH_SHOW} phase_t;

    phase_t        phase;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [31:0]   snap_value;
    logic [7:0]    snap_dp;
    logic [7:0]    snap_en;

    logic          lit;
    logic [3:0]    d0_nib, d1_nib;
    logic          d0_on, d1_on;
    logic [7:0]    d0_seg_nx, d1_seg_nx;
    logic [3:0]    d0_a_nx, d1_a_nx;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

`ifdef SEG7_BRIGHTNESS_EN
    // Extra 5 bits hold (brightness+1) * S without overflow before the >> 4.
    localparam int unsigned PW = CW + 5;
    logic [3:0]    snap_bright;
    logic [PW-1:0] on_limit;
    logic [PW-1:0] show_off;

    always_comb begin
        on_limit = ((PW'(snap_bright) + PW'(1)) * PW'(DWELL_CYCLES - BLANK_CYCLES)) >> 4;
        show_off = PW'(cnt) - PW'(BLANK_CYCLES);
        lit      = (phase == PH_SHOW) && (show_off < on_limit);
    end
`else
    always_comb begin
        lit = (phase == PH_SHOW);
    end
`endif

    always_comb begin
        d0_nib    = snap_value[{1'b0, idx, 2'b00} +: 4];
        d1_nib    = snap_value[{1'b1, idx, 2'b00} +: 4];
        d0_on     = lit && snap_en[{1'b0, idx}];
        d1_on     = lit && snap_en[{1'b1, idx}];
        d0_seg_nx = 8'hFF;
        d1_seg_nx = 8'hFF;
        d0_a_nx   = '1;
        d1_a_nx   = '1;
        if (d0_on) begin
            d0_seg_nx    = {~snap_dp[{1'b0, idx}], hex7(d0_nib)};
            d0_a_nx[idx] = 1'b0;
        end
        if (d1_on) begin
            d1_seg_nx    = {~snap_dp[{1'b1, idx}], hex7(d1_nib)};
            d1_a_nx[idx] = 1'b0;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            phase      <= PH_BLANK;
            idx        <= '0;
            cnt        <= '0;
            snap_value <= '0;
            snap_dp    <= '0;
            snap_en    <= '0;
`ifdef SEG7_BRIGHTNESS_EN
            snap_bright <= '0;
`endif
            D0_seg     <= '1;
            D1_seg     <= '1;
            D0_a       <= '1;
            D1_a       <= '1;
            frame_tick <= 1'b0;
        end else begin
            if (cnt == LAST_CNT) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            case (phase)
                PH_BLANK: if (cnt == BLANK_LAST) phase <= PH_SHOW;
                PH_SHOW:  if (cnt == LAST_CNT)   phase <= PH_BLANK;
                default:  phase <= PH_BLANK;
            endcase

            // Frame start falls in BLANK, so the new snapshot is in place
            // before any SHOW cycle reads it.
            if ((idx == 2'd0) && (cnt == '0)) begin
                snap_value <= value;
                snap_dp    <= dp;
                snap_en    <= digit_en;
`ifdef SEG7_BRIGHTNESS_EN
                snap_bright <= brightness;
`endif
            end

            D0_seg     <= d0_seg_nx;
            D1_seg     <= d1_seg_nx;
            D0_a       <= d0_a_nx;
            D1_a       <= d1_a_nx;
            frame_tick <= (idx == 2'd3) && (cnt == LAST_CNT);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Scoreboard bench for seg7_scan_driver with DWELL_CYCLES = 8,
//   BLANK_CYCLES = 2. The stimulus process queues the hand-computed expected
//   outputs for every clock; the monitor pops and compares one entry per cycle.
//   Define SEG7_BRIGHTNESS_EN to also exercise the brightness input.
module tb_seg7_scan_driver;

    localparam int unsigned DWELL = 8;
    localparam int unsigned BLANK = 2;

    logic        mclk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  digit_en;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]  brightness;
`endif
    logic [7:0]  D0_seg, D1_seg;
    logic [3:0]  D0_a, D1_a;
    logic        frame_tick;

    seg7_scan_driver #(
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .mclk       (mclk),
        .rst        (rst),
        .value      (value),
        .dp         (dp),
        .digit_en   (digit_en),
`ifdef SEG7_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .D0_seg     (D0_seg),
        .D1_seg     (D1_seg),
        .D0_a       (D0_a),
        .D1_a       (D1_a),
        .frame_tick (frame_tick)
    );

    initial forever #5 mclk = ~mclk;

    typedef struct {
        logic [3:0] a0;
        logic [7:0] s0;
        logic [3:0] a1;
        logic [7:0] s1;
        logic       tick;
        string      tag;
    } exp_t;

    exp_t  sb[$];
    exp_t  mon_e;
    int    n_checks = 0;
    int    n_errors = 0;
    string cur_tag  = "reset";

    // Monitor: outputs are sampled on the falling edge, one entry per cycle.
    initial begin
        forever begin
            @(negedge mclk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                n_checks++;
                if ({D0_a, D0_seg, D1_a, D1_seg, frame_tick} !==
                    {mon_e.a0, mon_e.s0, mon_e.a1, mon_e.s1, mon_e.tick}) begin
                    n_errors++;
                    $display("FAIL %s @%0t: got D0_a=%h D0_seg=%h D1_a=%h D1_seg=%h tick=%b, expected D0_a=%h D0_seg=%h D1_a=%h D1_seg=%h tick=%b",
                             mon_e.tag, $time, D0_a, D0_seg, D1_a, D1_seg, frame_tick,
                             mon_e.a0, mon_e.s0, mon_e.a1, mon_e.s1, mon_e.tick);
                end
            end
        end
    end

    // Queue the expected outputs after the next rising edge, then advance.
    task automatic step(input logic [3:0] a0, input logic [7:0] s0,
                        input logic [3:0] a1, input logic [7:0] s1,
                        input logic tick);
        exp_t e;
        e.a0 = a0; e.s0 = s0; e.a1 = a1; e.s1 = s1; e.tick = tick; e.tag = cur_tag;
        sb.push_back(e);
        @(negedge mclk);
    endtask

    task automatic blank_n(input int n);
        for (int i = 0; i < n; i++) step(4'hF, 8'hFF, 4'hF, 8'hFF, 1'b0);
    endtask

    task automatic show_n(input int n, input logic [3:0] a0, input logic [7:0] s0,
                          input logic [3:0] a1, input logic [7:0] s1,
                          input logic tick_last);
        for (int i = 0; i < n; i++) step(a0, s0, a1, s1, tick_last && (i == n - 1));
    endtask

    task automatic slot(input logic [3:0] a0, input logic [7:0] s0,
                        input logic [3:0] a1, input logic [7:0] s1,
                        input logic tick_last);
        blank_n(2);
        show_n(6, a0, s0, a1, s1, tick_last);
    endtask

    // value = 0x12345678, dp off, all digits enabled.
    task automatic frame_12345678();
        slot(4'hE, 8'h80, 4'hE, 8'h99, 1'b0);
        slot(4'hD, 8'hF8, 4'hD, 8'hB0, 1'b0);
        slot(4'hB, 8'h82, 4'hB, 8'hA4, 1'b0);
        slot(4'h7, 8'h92, 4'h7, 8'hF9, 1'b1);
    endtask

    task automatic frame_uniform(input logic [7:0] s);
        slot(4'hE, s, 4'hE, s, 1'b0);
        slot(4'hD, s, 4'hD, s, 1'b0);
        slot(4'hB, s, 4'hB, s, 1'b0);
        slot(4'h7, s, 4'h7, s, 1'b1);
    endtask

`ifdef SEG7_BRIGHTNESS_EN
    // brightness = 7: 3 lit cycles, then 3 dark cycles of SHOW.
    task automatic dim_slot(input logic [3:0] a, input logic tick_last);
        blank_n(2);
        show_n(3, a, 8'hC0, a, 8'hC0, 1'b0);
        blank_n(2);
        step(4'hF, 8'hFF, 4'hF, 8'hFF, tick_last);
    endtask
`endif

    initial begin
        rst      = 1'b1;
        value    = 32'h1234_5678;
        dp       = 8'h00;
        digit_en = 8'hFF;
`ifdef SEG7_BRIGHTNESS_EN
        brightness = 4'd15;
`endif
        cur_tag = "reset_hold";
        blank_n(3);
        rst = 1'b0;

        cur_tag = "reset_release";
        frame_12345678();

        cur_tag = "frame_tick";
        frame_12345678();
        frame_12345678();

        // Change mid-frame during digit 1 SHOW; must not appear until next frame.
        cur_tag = "snapshot";
        value = 32'h0000_0000;
        slot(4'hE, 8'hC0, 4'hE, 8'hC0, 1'b0);
        blank_n(2);
        show_n(3, 4'hD, 8'hC0, 4'hD, 8'hC0, 1'b0);
        value = 32'hFFFF_FFFF;
        show_n(3, 4'hD, 8'hC0, 4'hD, 8'hC0, 1'b0);
        slot(4'hB, 8'hC0, 4'hB, 8'hC0, 1'b0);
        slot(4'h7, 8'hC0, 4'h7, 8'hC0, 1'b1);
        cur_tag = "snapshot_next";
        frame_uniform(8'h8E);

        cur_tag = "dp_en";
        value    = 32'h0000_0000;
        dp       = 8'h01;
        digit_en = 8'hFE;
        slot(4'hF, 8'hFF, 4'hE, 8'hC0, 1'b0);
        slot(4'hD, 8'hC0, 4'hD, 8'hC0, 1'b0);
        slot(4'hB, 8'hC0, 4'hB, 8'hC0, 1'b0);
        slot(4'h7, 8'hC0, 4'h7, 8'hC0, 1'b1);

        cur_tag = "dp_map";
        dp       = 8'h24;
        digit_en = 8'hFF;
        slot(4'hE, 8'hC0, 4'hE, 8'hC0, 1'b0);
        slot(4'hD, 8'hC0, 4'hD, 8'h40, 1'b0);
        slot(4'hB, 8'h40, 4'hB, 8'hC0, 1'b0);
        slot(4'h7, 8'hC0, 4'h7, 8'hC0, 1'b1);

        // Reset for one cycle while digit 2 is shown.
        cur_tag = "mid_reset";
        dp    = 8'h00;
        value = 32'h1234_5678;
        slot(4'hE, 8'h80, 4'hE, 8'h99, 1'b0);
        slot(4'hD, 8'hF8, 4'hD, 8'hB0, 1'b0);
        blank_n(2);
        show_n(2, 4'hB, 8'h82, 4'hB, 8'hA4, 1'b0);
        rst   = 1'b1;
        value = 32'h9ABC_DEF0;
        blank_n(1);
        rst = 1'b0;
        cur_tag = "after_reset";
        slot(4'hE, 8'hC0, 4'hE, 8'hC6, 1'b0);
        slot(4'hD, 8'h8E, 4'hD, 8'h83, 1'b0);
        slot(4'hB, 8'h86, 4'hB, 8'h88, 1'b0);
        slot(4'h7, 8'hA1, 4'h7, 8'h90, 1'b1);

`ifdef SEG7_BRIGHTNESS_EN
        cur_tag = "bright_7";
        value      = 32'h0000_0000;
        brightness = 4'd7;
        dim_slot(4'hE, 1'b0);
        dim_slot(4'hD, 1'b0);
        dim_slot(4'hB, 1'b0);
        dim_slot(4'h7, 1'b1);
        cur_tag = "bright_15";
        brightness = 4'd15;
        frame_uniform(8'hC0);
`endif

        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
